// File: rtl/pri_enc_drain.sv
// Sequential priority encoder: accepts a multi-hot word, emits one index per set bit (LSB first;
// MSB first when PRI_ENC_MSB_FIRST_EN is defined). First beat one cycle after accept, then 1 beat/cycle.
// Backpressure: out_ready=0 holds the beat stable; a new word is accepted only as the last beat leaves.
module pri_enc_drain #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_bits,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          out_zero,
  output logic          busy
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   pending, pending_nxt;
  logic           zero_flag, zero_nxt;
  logic [IW-1:0]  idx;
  logic           one_hot;
  logic           beat_xfer;
  logic           accept;

  // The last matching assignment in the loop wins, which selects the priority end.
  always_comb begin
    idx = '0;
`ifdef PRI_ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (pending[i]) idx = IW'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) idx = IW'(i);
    end
`endif
  end

  assign one_hot   = (pending != '0) && ((pending & (pending - N'(1))) == '0);

  assign out_valid = (state == DRAIN);
  assign busy      = (state == DRAIN);
  assign out_idx   = idx;
  assign out_last  = (state == DRAIN) && (one_hot || zero_flag);
  assign out_zero  = (state == DRAIN) && zero_flag;

  assign beat_xfer = out_valid && out_ready;
  assign in_ready  = en && ((state == IDLE) || (beat_xfer && out_last));
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    zero_nxt    = zero_flag;
    if (beat_xfer) begin
      pending_nxt = pending & ~(N'(1) << idx);
      if (out_last) begin
        state_nxt = IDLE;
        zero_nxt  = 1'b0;
      end
    end
    // A same-cycle accept overrides the return to IDLE, giving bubble-free words.
    if (accept) begin
      pending_nxt = in_bits;
      zero_nxt    = (in_bits == '0);
      state_nxt   = DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      zero_flag <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      zero_flag <= zero_nxt;
    end
  end

endmodule

// File: doc/pri_enc_drain.md
Name: pri_enc_drain

Overview:
Sequential 8-to-3 priority encoder; the encoding counterpart of the team's 3-to-8 enabled decoder.
- Accepts a multi-hot request word over a valid/ready handshake.
- Emits the index of every set bit, one per beat, in priority order, over a second valid/ready handshake, with a last-beat flag.
- Sits between request-collection logic and any consumer that wants indices rather than bit vectors; drives the decoder side, which re-expands indices.

Parameters:
N, 8, request word width; must be a power of two, range 2 to 64.
IW, 3, index width; must equal log2(N). Out-of-range or mismatched values are illegal; the bench checks only the defaults.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  acceptance enable; 0 blocks new words only
in_valid  input  1  request word present
in_ready  output  1  block can accept a word this cycle
in_bits  input  N  request word, bit i = request i
out_valid  output  1  beat present
out_ready  input  1  consumer accepts beat
out_idx  output  IW  encoded index of current bit
out_last  output  1  current beat is final beat of the word
out_zero  output  1  current beat represents an all-zero word
busy  output  1  word held, beats outstanding

Behaviour:
- Reset (async assert, sync release): state=IDLE, pending=0, zero_flag=0. Reset values: out_valid=0, out_idx=0, out_last=0, out_zero=0, busy=0. in_ready=en, per the rule below.
- Reset mid-drain discards all remaining beats; no beat is emitted after reset release until a new word is accepted.
- States: IDLE, DRAIN.
- in_ready = en && (IDLE || (out_valid && out_ready && out_last)).
- in_ready is the only output with a combinational path from en, out_ready and the state. All other outputs are decoded from registers only.
- Accept occurs when in_valid && in_ready at a rising edge:
  - in_bits != 0: pending <= in_bits, zero_flag <= 0, state <= DRAIN.
  - in_bits == 0: pending <= 0, zero_flag <= 1, state <= DRAIN. This produces exactly one beat: out_idx=0, out_zero=1, out_last=1.
- Latency: the first beat is valid in the cycle after acceptance. There is no combinational path from in_* to out_*.
- In DRAIN:
  - out_valid=1, busy=1.
  - out_idx = position of the lowest set bit of pending (LSB = highest priority).
  - out_last=1 when pending has exactly one bit set, or zero_flag=1.
- Beat transfer occurs on out_valid && out_ready at a rising edge:
  - The bit at out_idx is cleared in pending.
  - If out_last: go to IDLE, unless a new word is accepted in the same cycle; then reload and stay in DRAIN. This gives back-to-back words with no bubble.
- Backpressure: while out_ready=0, out_idx, out_last and out_zero are held stable and out_valid stays 1.
- en=0 during DRAIN: the drain continues normally; only acceptance is blocked. If en=0 when the last beat is taken, go to IDLE.
- Throughput: one beat per cycle. A word with k set bits occupies exactly k beats.
- pending never wraps; the index always lies in 0..N-1.

Optional Feature:
Macro PRI_ENC_MSB_FIRST_EN.
- Defined: priority is reversed. out_idx is the highest set bit of pending, and beats come out in descending index order. out_last and zero-word handling are unchanged.
- Undefined: LSB-first ordering as above.
- Handshake timing is identical in both builds.

Test Plan:
- LSB-first ordering: en=1, out_ready=1, accept 8'b1010_0100 -> three beats with out_idx 2, 5, 7. out_last=1 only on idx 7. in_ready=0 during the beats for idx 2 and 5.
- Zero word: accept 8'h00 -> one beat with out_idx=0, out_zero=1, out_last=1. Then IDLE, busy=0.
- Back-to-back: 8'h80 then 8'h01 with in_valid held -> beats 7(last), 0(last) on consecutive cycles. in_ready=1 in the cycle beat 7 transfers; no bubble.
- Backpressure: accept 8'h12, hold out_ready=0 for 3 cycles -> out_idx=1 and out_valid=1 stay stable. Release -> beats 1, 4(last).
- en and reset: en=0 with in_valid=1 -> in_ready=0 and no accept. Accept 8'hFF, take 3 beats (idx 0, 1, 2), assert rst_n=0 -> out_valid=0 and busy=0 immediately, with no further beats after release.
- PRI_ENC_MSB_FIRST_EN build: accept 8'b1010_0100 -> beats 7, 5, 2(last).
